// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - WIDTH-generic ALU with iterative RV32M multiply/divide.
// Divide opcodes 14-17 are built only when MULTICYCLE_ALU_DIV_EN is defined.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       operation,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         r_state;
  logic [4:0]         r_op;
  logic [WIDTH-1:0]   r_op1;
  logic [WIDTH-1:0]   r_op2;
  logic [WIDTH-1:0]   r_m;
  logic [2*WIDTH-1:0] r_acc;
  logic [SW-1:0]      r_cnt;
  logic               r_neg;
  logic               r_valid;
  logic               r_illegal;
  logic [WIDTH-1:0]   r_result;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_special;
  logic               w_iter_start;
  logic [SW-1:0]      w_sh;
  logic [WIDTH-1:0]   w_fast;
  logic               w_fast_ill;
  logic               w_a_sgn;
  logic               w_b_sgn;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_final;

  // FIX is the valid cycle; it accepts like IDLE so back-to-back issue works.
  assign ready    = (r_state == S_IDLE) || (r_state == S_FIX);
  assign valid    = r_valid;
  assign result   = r_result;
  assign illegal  = r_illegal;
  assign w_accept = start && ready;
  assign w_sh     = operand_2[SW-1:0];
  assign w_is_mul = (operation >= 5'd10) && (operation <= 5'd13);

`ifdef MULTICYCLE_ALU_DIV_EN
  logic             r_rneg;
  logic             w_div_zero;
  logic             w_div_ovf;
  logic [WIDTH-1:0] w_dsh;
  logic             w_dge;
  logic [WIDTH-1:0] w_dhi;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign w_is_div   = (operation >= 5'd14) && (operation <= 5'd17);
  assign w_div_zero = (operand_2 == '0);
  assign w_div_ovf  = ((operation == 5'd14) || (operation == 5'd16)) &&
                      (operand_1 == MOST_NEG) && (operand_2 == '1);
  assign w_special  = w_is_div && (w_div_zero || w_div_ovf);

  // Restoring step: the bit shifted out of the remainder forces a subtract.
  assign w_dsh = {r_acc[2*WIDTH-2:WIDTH], r_acc[WIDTH-1]};
  assign w_dge = r_acc[2*WIDTH-1] | (w_dsh >= r_m);
  assign w_dhi = w_dge ? (w_dsh - r_m) : w_dsh;
  assign w_quo = r_neg  ? -w_acc_next[WIDTH-1:0]       : w_acc_next[WIDTH-1:0];
  assign w_rem = r_rneg ? -w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[2*WIDTH-1:WIDTH];
`else
  assign w_is_div  = 1'b0;
  assign w_special = 1'b0;
`endif

  assign w_iter_start = w_is_mul || (w_is_div && !w_special);

  always_comb begin
    w_fast     = '0;
    w_fast_ill = 1'b0;
    case (operation)
      5'd0: w_fast = operand_1 + operand_2;
      5'd1: w_fast = operand_1 - operand_2;
      5'd2: w_fast = operand_1 << w_sh;
      5'd3: w_fast = {{(WIDTH-1){1'b0}}, ($signed(operand_1) < $signed(operand_2))};
      5'd4: w_fast = {{(WIDTH-1){1'b0}}, (operand_1 < operand_2)};
      5'd5: w_fast = operand_1 ^ operand_2;
      5'd6: w_fast = operand_1 >> w_sh;
      5'd7: w_fast = $signed(operand_1) >>> w_sh;
      5'd8: w_fast = operand_1 | operand_2;
      5'd9: w_fast = operand_1 & operand_2;
`ifdef MULTICYCLE_ALU_DIV_EN
      5'd14, 5'd15: w_fast = w_div_zero ? '1 : MOST_NEG;
      5'd16, 5'd17: w_fast = w_div_zero ? operand_1 : '0;
`endif
      default: w_fast_ill = 1'b1;
    endcase
  end

  assign w_a_sgn = r_op1[WIDTH-1] && ((r_op == 5'd11) || (r_op == 5'd12) ||
                                      (r_op == 5'd14) || (r_op == 5'd16));
  assign w_b_sgn = r_op2[WIDTH-1] && ((r_op == 5'd11) || (r_op == 5'd14) ||
                                      (r_op == 5'd16));
  assign w_a_mag = w_a_sgn ? -r_op1 : r_op1;
  assign w_b_mag = w_b_sgn ? -r_op2 : r_op2;

  // Shift-add: multiplier sits in the low half and drains out of bit 0.
  assign w_msum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);

  always_comb begin
`ifdef MULTICYCLE_ALU_DIV_EN
    if (r_op >= 5'd14) begin
      w_acc_next = {w_dhi, r_acc[WIDTH-2:0], w_dge};
    end else begin
      w_acc_next = {w_msum, r_acc[WIDTH-1:1]};
    end
`else
    w_acc_next = {w_msum, r_acc[WIDTH-1:1]};
`endif
  end

  assign w_prod = r_neg ? -w_acc_next : w_acc_next;

  always_comb begin
    w_final = (r_op == 5'd10) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
`ifdef MULTICYCLE_ALU_DIV_EN
    if ((r_op == 5'd14) || (r_op == 5'd15)) begin
      w_final = w_quo;
    end else if ((r_op == 5'd16) || (r_op == 5'd17)) begin
      w_final = w_rem;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_m       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_result  <= '0;
`ifdef MULTICYCLE_ALU_DIV_EN
      r_rneg    <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_FIX: begin
          r_state <= S_IDLE;
          if (w_accept) begin
            r_op <= operation;
            if (w_iter_start) begin
              r_op1   <= operand_1;
              r_op2   <= operand_2;
              r_state <= S_LOAD;
            end else begin
              r_result  <= w_fast;
              r_illegal <= w_fast_ill;
              r_valid   <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          r_cnt   <= '0;
          r_neg   <= w_a_sgn ^ w_b_sgn;
          r_state <= S_ITER;
`ifdef MULTICYCLE_ALU_DIV_EN
          r_rneg  <= w_a_sgn;
          if (r_op >= 5'd14) begin
            r_m   <= w_b_mag;
            r_acc <= {{WIDTH{1'b0}}, w_a_mag};
          end else begin
            r_m   <= w_a_mag;
            r_acc <= {{WIDTH{1'b0}}, w_b_mag};
          end
`else
          r_m     <= w_a_mag;
          r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
`endif
        end
        S_ITER: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == SW'(WIDTH - 1)) begin
            r_result  <= w_final;
            r_illegal <= 1'b0;
            r_valid   <= 1'b1;
            r_state   <= S_FIX;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - directed self-checking bench for multicycle_alu.
// Divide vectors follow MULTICYCLE_ALU_DIV_EN; illegal-divide vectors otherwise.
module tb_multicycle_alu;

  logic        clock;
  logic        reset;
  logic        start;
  logic [4:0]  operation;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        ready;
  logic        valid;
  logic [31:0] result;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] res;
  logic        ill;
  int          lat;
  logic        rdy1;

  multicycle_alu #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .operation (operation),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .ready     (ready),
    .valid     (valid),
    .result    (result),
    .illegal   (illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one op and wait (bounded) for valid; lat counts edges from accept.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] o_res, output logic o_ill, output int o_lat,
                        output logic o_rdy1);
    start     = 1'b1;
    operation = op;
    operand_1 = a;
    operand_2 = b;
    tick();
    start  = 1'b0;
    o_lat  = 1;
    o_rdy1 = ready;
    while (!valid && o_lat < 100) begin
      tick();
      o_lat++;
    end
    o_res = result;
    o_ill = illegal;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    operation = '0;
    operand_1 = '0;
    operand_2 = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("reset_ready",   ready,   1'b1);
    chk("reset_valid",   valid,   1'b0);
    chk("reset_result",  result,  32'h0);
    chk("reset_illegal", illegal, 1'b0);
    tick();
    chk("idle_valid", valid, 1'b0);

    // ADD then OR back to back
    start = 1'b1; operation = 5'd0; operand_1 = 32'd7; operand_2 = 32'hFFFF_FFFD;
    tick();
    chk("add_valid", valid, 1'b1);
    chk("add_result", result, 32'd4);
    operation = 5'd8; operand_1 = 32'hF0; operand_2 = 32'h0F;
    tick();
    start = 1'b0;
    chk("or_valid", valid, 1'b1);
    chk("or_result", result, 32'hFF);
    tick();
    chk("pulse_end", valid, 1'b0);

    run_op(5'd1, 32'd5, 32'd7, res, ill, lat, rdy1);
    chk("sub", res, 32'hFFFF_FFFE);
    chk("sub_lat", lat, 1);
    chk("sub_ill", ill, 1'b0);
    run_op(5'd2, 32'd1, 32'd33, res, ill, lat, rdy1);
    chk("sll_shamt_low5", res, 32'd2);
    run_op(5'd3, 32'hFFFF_FFFF, 32'd1, res, ill, lat, rdy1);
    chk("slt", res, 32'd1);
    run_op(5'd4, 32'hFFFF_FFFF, 32'd1, res, ill, lat, rdy1);
    chk("sltu", res, 32'd0);
    run_op(5'd5, 32'hA5A5_0000, 32'hFFFF_00FF, res, ill, lat, rdy1);
    chk("xor", res, 32'h5A5A_00FF);
    run_op(5'd6, 32'h8000_0000, 32'd4, res, ill, lat, rdy1);
    chk("srl", res, 32'h0800_0000);
    run_op(5'd7, 32'h8000_0000, 32'd4, res, ill, lat, rdy1);
    chk("sra", res, 32'hF800_0000);
    run_op(5'd9, 32'hF0F0_1234, 32'h0FF0_FFFF, res, ill, lat, rdy1);
    chk("and", res, 32'h00F0_1234);

    run_op(5'd10, 32'hFFFF_FFFE, 32'd3, res, ill, lat, rdy1);
    chk("mul", res, 32'hFFFF_FFFA);
    chk("mul_lat", lat, 34);
    chk("mul_busy", rdy1, 1'b0);
    chk("mul_ready_on_valid", ready, 1'b1);
    chk("mul_ill", ill, 1'b0);
    run_op(5'd11, 32'hFFFF_FFFE, 32'd3, res, ill, lat, rdy1);
    chk("mulh", res, 32'hFFFF_FFFF);
    chk("mulh_lat", lat, 34);
    run_op(5'd13, 32'hFFFF_FFFE, 32'd3, res, ill, lat, rdy1);
    chk("mulhu", res, 32'h0000_0002);
    run_op(5'd12, 32'hFFFF_FFFE, 32'hFFFF_FFFF, res, ill, lat, rdy1);
    chk("mulhsu", res, 32'hFFFF_FFFE);
    run_op(5'd11, 32'hFFFF_FFFE, 32'hFFFF_FFFF, res, ill, lat, rdy1);
    chk("mulh_negneg", res, 32'h0000_0000);

`ifdef MULTICYCLE_ALU_DIV_EN
    run_op(5'd14, 32'hFFFF_FFF9, 32'd2, res, ill, lat, rdy1);
    chk("div", res, 32'hFFFF_FFFD);
    chk("div_lat", lat, 34);
    run_op(5'd16, 32'hFFFF_FFF9, 32'd2, res, ill, lat, rdy1);
    chk("rem", res, 32'hFFFF_FFFF);
    run_op(5'd15, 32'd100, 32'd7, res, ill, lat, rdy1);
    chk("divu", res, 32'd14);
    run_op(5'd16, 32'd100, 32'hFFFF_FFF9, res, ill, lat, rdy1);
    chk("rem_negdivisor", res, 32'd2);
    run_op(5'd15, 32'd5, 32'd0, res, ill, lat, rdy1);
    chk("divu_zero", res, 32'hFFFF_FFFF);
    chk("divu_zero_lat", lat, 1);
    run_op(5'd17, 32'd5, 32'd0, res, ill, lat, rdy1);
    chk("remu_zero", res, 32'd5);
    run_op(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, res, ill, lat, rdy1);
    chk("div_ovf", res, 32'h8000_0000);
    chk("div_ovf_lat", lat, 1);
    run_op(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, res, ill, lat, rdy1);
    chk("rem_ovf", res, 32'h0);
    chk("rem_ovf_ill", ill, 1'b0);
`else
    run_op(5'd14, 32'd6, 32'd3, res, ill, lat, rdy1);
    chk("div_disabled_ill", ill, 1'b1);
    chk("div_disabled_res", res, 32'h0);
    chk("div_disabled_lat", lat, 1);
`endif

    run_op(5'd20, 32'd1, 32'd2, res, ill, lat, rdy1);
    chk("op20_ill", ill, 1'b1);
    chk("op20_res", res, 32'h0);
    chk("op20_lat", lat, 1);

    // Reset on ITER step 10 (edge 12 counting the accept edge) with start held
    start = 1'b1; operation = 5'd10; operand_1 = 32'd12345; operand_2 = 32'd678;
    for (int i = 0; i < 11; i++) tick();
    chk("held_start_busy", ready, 1'b0);
    reset = 1'b1;
    tick();
    chk("midreset_ready",  ready,  1'b1);
    chk("midreset_valid",  valid,  1'b0);
    chk("midreset_result", result, 32'h0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk("postreset_idle", valid, 1'b0);
    run_op(5'd0, 32'd1, 32'd1, res, ill, lat, rdy1);
    chk("postreset_add", res, 32'd2);
    chk("postreset_add_lat", lat, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised, multi-cycle successor to the single-cycle CPU ALU. It adds a registered start/valid handshake and a WIDTH-generic datapath. It also adds the RV32M multiply/divide/remainder family, executed iteratively (one bit per cycle). It sits between the instruction decoder and the register-file write-back mux, and the core stalls while `ready` is low.

## Interface
- `WIDTH`, 32: operand/result width; power of two, ≥ 8; shift amount is the low $clog2(WIDTH) bits of `operand_2`.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: reset is synchronous and active-high.
- `start`  in  1: request; accepted on a rising edge when `start && ready`.
- `operation`  in  5: opcode, sampled on accept.
- `operand_1`  in  WIDTH: first operand, sampled on accept.
- `operand_2`  in  WIDTH: second operand, sampled on accept.
- `ready`  out  1: unit idle, able to accept.
- `valid`  out  1: one-cycle pulse; `result` is new this cycle.
- `result`  out  WIDTH: registered result, held until the next completion.
- `illegal`  out  1: qualified by `valid`; the completed opcode was unsupported.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU.
  - 14 DIV, 15 DIVU, 16 REM, 17 REMU.
  - 18–31 illegal: `result`=0, `illegal`=1.
- SLT/SLTU produce 0 or 1, zero-extended.
- FSM states:
  - IDLE: `ready`=1. Accepting a single-cycle op stays in IDLE and registers the result. Accepting MUL*/DIV* goes to LOAD.
  - LOAD: latch operand magnitudes and the result sign; clear the 2·WIDTH accumulator; counter=0; go to ITER.
  - ITER: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. After WIDTH steps go to FIX.
  - FIX: apply sign correction, select the low half (MUL), high half (MULH*), quotient or remainder; register `result`; pulse `valid`; go to IDLE.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: `operand_1` signed, `operand_2` unsigned.
  - MULHU: both unsigned.
  - DIV and REM are signed; quotient truncates toward zero; remainder takes the dividend's sign.
- Divide special cases are resolved in IDLE with single-cycle latency:
  - Divisor 0: quotient all-ones; remainder = dividend.
  - Signed overflow (most-negative / −1): quotient = most-negative; remainder 0.
- `start` while `ready`=0 is ignored, with no queuing. Operands may change freely after accept.
- Reset at any point, including mid-ITER: next state IDLE; `ready`=1, `valid`=0, `illegal`=0, `result`=0, counter=0.

## Timing
- Latency L is counted in rising edges, with the accepting edge counted as 1. `valid` is high for exactly the cycle following edge L.
- Single-cycle ops, illegal ops, and divide special cases: L=1.
- MUL*/DIV*/REM*: L=WIDTH+2, from 1 LOAD edge, WIDTH ITER edges and 1 FIX edge.
- `ready` is high in the same cycle as `valid`, so back-to-back issue is allowed.
- With single-cycle ops, throughput is one per cycle.
- `ready` is low from the cycle after an iterative accept until the `valid` cycle.
- Reset values: `ready`=1, `valid`=0, `result`=0, `illegal`=0.

## Configuration
- `MULTICYCLE_ALU_DIV_EN` defined: opcodes 14–17 are implemented as above.
- Not defined:
  - Opcodes 14–17 are illegal: L=1, `result`=0, `illegal`=1.
  - The divide datapath and the divide special-case logic are removed.
  - The multiply opcodes are unaffected.

## Test plan
All scenarios use WIDTH=32.
- Reset, then idle → `ready`=1, `valid`=0, `result`=0.
- ADD 7, 0xFFFFFFFD, then back-to-back OR 0xF0, 0x0F → `valid` on 2 consecutive cycles with `result` 4 then 0xFF.
- MUL 0xFFFFFFFE×3 → 0xFFFFFFFA at L=34. MULH same operands → 0xFFFFFFFF. MULHU same operands → 0x00000002.
- With `MULTICYCLE_ALU_DIV_EN`, DIV 0xFFFFFFF9/2 → 0xFFFFFFFD at L=34; REM same operands → 0xFFFFFFFF.
- With `MULTICYCLE_ALU_DIV_EN`:
  - DIVU 5/0 → 0xFFFFFFFF at L=1.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000 at L=1.
  - REM same operands → 0.
- Assert `start` continuously during MUL, then assert `reset` on ITER step 10 → next cycle `ready`=1, `valid`=0, `result`=0. A following ADD 1, 1 → 2 at L=1.
- Without the macro, DIV 6/3 → `illegal`=1, `result`=0 at L=1. Opcode 20 → `illegal`=1 in both builds.
